// File: rtl/cell_mem_arbiter_if.sv
// Requester-side bus of the cell memory arbiter: packed per-requester
// request fields and the shared one-hot response.
interface cell_mem_arbiter_if #(
    parameter int NumReq    = 3,
    parameter int AddrWidth = 12,
    parameter int DataWidth = 16
);
    logic [NumReq-1:0]           req_valid;
    logic [NumReq-1:0]           req_ready;
    logic [NumReq-1:0]           req_we;
    logic [NumReq-1:0]           req_lock;
    logic [NumReq*AddrWidth-1:0] req_addr;
    logic [NumReq*DataWidth-1:0] req_wdata;
    logic [NumReq-1:0]           rsp_valid;
    logic [DataWidth-1:0]        rsp_rdata;
    logic                        rsp_err;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/cell_mem_arbiter.sv
// Round-robin arbiter sharing the single-port cell memory between requesters,
// with an optional grant lock for multi-word atomic sequences and a lock timeout.
module cell_mem_arbiter #(
    parameter int  NumReq      = 3,
    parameter int  AddrWidth   = 12,
    parameter int  DataWidth   = 16,
    parameter int  MemorySize  = 256,
    parameter int  LockTimeout = 64,
    localparam int MemAw       = $clog2(MemorySize),
    localparam int OwnerW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    cell_mem_arbiter_if.slave    bus,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [MemAw-1:0]     mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 lock_active,
    output logic [OwnerW-1:0]    lock_owner,
    output logic                 lock_timeout
);

    localparam int                 CntW       = (LockTimeout > 1) ? $clog2(LockTimeout) : 1;
    localparam logic [CntW-1:0]    TimeoutCnt = CntW'(LockTimeout - 1);
    localparam logic [OwnerW-1:0]  LastIdx    = OwnerW'(NumReq - 1);
    localparam logic [AddrWidth:0] MemLimit   = (AddrWidth + 1)'(MemorySize);

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } lock_state_e;

    lock_state_e          state_q, state_d;
    logic [OwnerW-1:0]    owner_q, owner_d;
    logic [OwnerW-1:0]    rr_q, rr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [OwnerW-1:0]    winner;
    logic                 grant_hit;
    logic                 timeout_fire;
    logic [NumReq-1:0]    ready;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;
    logic                 sel_we;
    logic                 sel_lock;
    logic                 in_range;
    logic [NumReq-1:0]    rsp_pend_q;
    logic                 rsp_rd_q;
    logic                 rsp_err_q;

    function automatic logic [OwnerW-1:0] next_idx(input logic [OwnerW-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + OwnerW'(1);
    endfunction

    assign timeout_fire = (state_q == ST_LOCKED) && (cnt_q == TimeoutCnt);

    // Grant selection; held in reset so nothing is accepted while rst is low.
    always_comb begin
        grant_hit = 1'b0;
        winner    = '0;
        if (rst) begin
            if (state_q == ST_LOCKED) begin
                if (!timeout_fire && bus.req_valid[owner_q]) begin
                    grant_hit = 1'b1;
                    winner    = owner_q;
                end
            end else begin
                for (int k = 0; k < NumReq; k++) begin
                    if (!grant_hit && bus.req_valid[(int'(rr_q) + k) % NumReq]) begin
                        grant_hit = 1'b1;
                        winner    = OwnerW'((int'(rr_q) + k) % NumReq);
                    end
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        if (grant_hit) begin
            ready[winner] = 1'b1;
        end
        sel_addr  = bus.req_addr[winner*AddrWidth +: AddrWidth];
        sel_wdata = bus.req_wdata[winner*DataWidth +: DataWidth];
        sel_we    = bus.req_we[winner];
        sel_lock  = bus.req_lock[winner];
        in_range  = ({1'b0, sel_addr} < MemLimit);
        mem_en    = grant_hit && in_range;
        mem_we    = mem_en && sel_we;
        mem_addr  = mem_en ? sel_addr[MemAw-1:0] : '0;
        mem_wdata = mem_en ? sel_wdata : '0;
    end

    // Lock FSM, idle counter and round-robin pointer next-state.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (grant_hit) begin
                    rr_d = next_idx(winner);
                    if (sel_lock) begin
                        state_d = ST_LOCKED;
                        owner_d = winner;
                        cnt_d   = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (timeout_fire) begin
                    state_d = ST_UNLOCKED;
                    owner_d = '0;
                    cnt_d   = '0;
                    rr_d    = next_idx(owner_q);
                end else if (grant_hit) begin
                    cnt_d = '0;
                    if (!sel_lock) begin
                        state_d = ST_UNLOCKED;
                        owner_d = '0;
                        rr_d    = next_idx(owner_q);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                owner_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_UNLOCKED;
            owner_q <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // Response is the accept of the previous cycle; reset drops it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_pend_q <= '0;
            rsp_rd_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            rsp_pend_q <= ready;
            rsp_rd_q   <= grant_hit && in_range && !sel_we;
            rsp_err_q  <= grant_hit && !in_range;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_pend_q;
    assign bus.rsp_rdata = rsp_rd_q ? mem_rdata : '0;
    assign bus.rsp_err   = rsp_err_q;
    assign lock_active   = (state_q == ST_LOCKED);
    assign lock_owner    = (state_q == ST_LOCKED) ? owner_q : '0;
    assign lock_timeout  = timeout_fire;

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Self-checking bench for cell_mem_arbiter: directed scenarios plus a response
// scoreboard fed from every observed accept.
module tb_cell_mem_arbiter;

    localparam int NumReq     = 3;
    localparam int AddrWidth  = 12;
    localparam int DataWidth  = 16;
    localparam int MemorySize = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        lock_active;
    logic [1:0]  lock_owner;
    logic        lock_timeout;

    cell_mem_arbiter_if #(.NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth)) bus();

    cell_mem_arbiter #(
        .NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth),
        .MemorySize(MemorySize), .LockTimeout(64)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lock_active(lock_active), .lock_owner(lock_owner), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [MemorySize];

    // Synchronous single-port memory, cleared and preloaded while in reset.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MemorySize; i++) mem[i] <= 16'h0000;
            mem[1]    <= 16'hDEAD;
            mem_rdata <= 16'h0000;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic [2:0]  vld;
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        expq[$];
    logic [15:0] shadow [MemorySize];
    int          numChecks = 0;
    int          numFails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitorCycle();
        rsp_t        e;
        logic [2:0]  acc;
        logic [11:0] addr;
        logic        we;
        logic        inr;
        if (!rst) begin
            expq.delete();
            for (int i = 0; i < MemorySize; i++) shadow[i] <= 16'h0000;
            shadow[1] <= 16'hDEAD;
        end else begin
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("sb_rsp_valid", 32'(bus.rsp_valid), 32'(e.vld));
                checkOutput("sb_rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                checkOutput("sb_rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end else if (bus.rsp_valid != 3'b000) begin
                checkOutput("sb_rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end
            acc = bus.req_valid & bus.req_ready;
            for (int i = 0; i < NumReq; i++) begin
                if (acc[i]) begin
                    addr = bus.req_addr[i*AddrWidth +: AddrWidth];
                    we   = bus.req_we[i];
                    inr  = (addr < 12'(MemorySize));
                    checkOutput("sb_mem_en", 32'(mem_en), 32'(inr));
                    if (inr) begin
                        checkOutput("sb_mem_addr", 32'(mem_addr), 32'(addr[7:0]));
                        checkOutput("sb_mem_we", 32'(mem_we), 32'(we));
                        if (we) begin
                            checkOutput("sb_mem_wdata", 32'(mem_wdata),
                                        32'(bus.req_wdata[i*DataWidth +: DataWidth]));
                            shadow[addr[7:0]] <= bus.req_wdata[i*DataWidth +: DataWidth];
                        end
                    end
                    e.vld   = 3'(1 << i);
                    e.rdata = (inr && !we) ? shadow[addr[7:0]] : 16'h0000;
                    e.err   = !inr;
                    expq.push_back(e);
                end
            end
        end
    endtask

    always @(negedge clk) monitorCycle();

    task automatic applyStimulus(input int idx, input logic vld, input logic we, input logic lock,
                                 input logic [11:0] addr, input logic [15:0] wdata);
        bus.req_valid[idx]                          = vld;
        bus.req_we[idx]                             = we;
        bus.req_lock[idx]                           = lock;
        bus.req_addr[idx*AddrWidth +: AddrWidth]    = addr;
        bus.req_wdata[idx*DataWidth +: DataWidth]   = wdata;
    endtask

    task automatic clearAll();
        for (int i = 0; i < NumReq; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
    endtask

    task automatic nextDrive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        numFails++;
        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idle;
        clearAll();
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h001, 16'h0000);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 12'h002, 16'h0000);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 12'h003, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_lock_active", 32'(lock_active), 32'd0);
        checkOutput("rst_lock_owner", 32'(lock_owner), 32'd0);
        checkOutput("rst_lock_timeout", 32'(lock_timeout), 32'd0);

        // Round-robin with all three requesters valid from reset release.
        nextDrive();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 3)));
        end
        nextDrive();
        clearAll();

        // Single read of the preloaded cell.
        nextDrive();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h001, 16'h0000);
        @(negedge clk);
        checkOutput("rd_ready", 32'(bus.req_ready), 32'b001);
        checkOutput("rd_mem_en", 32'(mem_en), 32'd1);
        checkOutput("rd_mem_addr", 32'(mem_addr), 32'h01);
        nextDrive();
        clearAll();
        @(negedge clk);
        checkOutput("rd_rsp_valid", 32'(bus.rsp_valid), 32'b001);
        checkOutput("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'hDEAD);
        checkOutput("rd_rsp_err", 32'(bus.rsp_err), 32'd0);

        // Out-of-range host read.
        nextDrive();
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 12'h100, 16'h0000);
        @(negedge clk);
        checkOutput("oor_ready", 32'(bus.req_ready), 32'b100);
        checkOutput("oor_mem_en", 32'(mem_en), 32'd0);
        nextDrive();
        clearAll();
        @(negedge clk);
        checkOutput("oor_rsp_valid", 32'(bus.rsp_valid), 32'b100);
        checkOutput("oor_rsp_err", 32'(bus.rsp_err), 32'd1);
        checkOutput("oor_rsp_rdata", 32'(bus.rsp_rdata), 32'h0000);

        // Atomic cons: allocator writes car/cdr under lock, evaluator waits.
        nextDrive();
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 12'h004, 16'h0002);
        @(negedge clk);
        checkOutput("cons_ready1", 32'(bus.req_ready), 32'b010);
        checkOutput("cons_lock_pre", 32'(lock_active), 32'd0);
        nextDrive();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 12'h003, 16'h0001);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h004, 16'h0000);
        @(negedge clk);
        checkOutput("cons_lock_active", 32'(lock_active), 32'd1);
        checkOutput("cons_lock_owner", 32'(lock_owner), 32'd1);
        checkOutput("cons_ready2", 32'(bus.req_ready), 32'b010);
        nextDrive();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checkOutput("cons_lock_released", 32'(lock_active), 32'd0);
        checkOutput("cons_eval_grant", 32'(bus.req_ready), 32'b001);
        nextDrive();
        clearAll();
        @(negedge clk);
        checkOutput("cons_eval_rdata", 32'(bus.rsp_rdata), 32'h0002);

        // Lock timeout: owner goes idle while requester 1 waits.
        nextDrive();
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 12'h001, 16'h0000);
        @(negedge clk);
        checkOutput("to_lock_grant", 32'(bus.req_ready), 32'b001);
        nextDrive();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 12'h002, 16'h0000);
        idle = 0;
        while (idle < 200) begin
            @(negedge clk);
            idle++;
            if (lock_timeout) break;
        end
        checkOutput("to_idle_cycles", 32'(idle), 32'd64);
        checkOutput("to_fire_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        checkOutput("to_waiter_grant", 32'(bus.req_ready), 32'b010);
        checkOutput("to_unlocked", 32'(lock_active), 32'd0);
        nextDrive();
        clearAll();
        @(negedge clk);

        // Reset asserted in the cycle a read is accepted.
        nextDrive();
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 12'h001, 16'h0000);
        @(negedge clk);
        checkOutput("mr_grant", 32'(bus.req_ready), 32'b001);
        #1;
        rst = 1'b0;
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 12'h002, 16'h0000);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 12'h003, 16'h0000);
        #1;
        checkOutput("mr_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("mr_mem_en", 32'(mem_en), 32'd0);
        checkOutput("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mr_no_rsp", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mr_first_grant", 32'(bus.req_ready), 32'b001);
        nextDrive();
        clearAll();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $finish;
    end

endmodule
